// File: rtl/fib_arbiter.sv
// -----------------------------------------------------------------------------
// fib_arbiter
//
// Shares one fib unit among NUM_REQ requesters. A round-robin arbiter picks a
// requester in IDLE, the sequencer pulses fib_go with the latched operand,
// waits for a fresh fib_done and hands result/overflow back to the winner with
// a one-cycle resp_valid pulse. A watchdog aborts jobs whose done never shows.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   req           per-requester level request
//   req_n         packed operands, requester i at [i*INPUT_WIDTH +: INPUT_WIDTH]
//   ack           one-hot one-cycle acceptance pulse
//   resp_valid    one-hot one-cycle response pulse
//   resp_result   result of the last completed job
//   resp_overflow overflow flag of the last completed job
//   resp_error    1 = last job was aborted by the watchdog
//   busy          1 in every state except IDLE
//   fib_go        go pulse to the fib unit
//   fib_n         operand to the fib unit, stable for the whole job
//   fib_result    result from the fib unit
//   fib_overflow  overflow from the fib unit
//   fib_done      done from the fib unit
// -----------------------------------------------------------------------------
module fib_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 6,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [OUTPUT_WIDTH-1:0]        resp_result,
  output logic                           resp_overflow,
  output logic                           resp_error,
  output logic                           busy,
  output logic                           fib_go,
  output logic [INPUT_WIDTH-1:0]         fib_n,
  input  logic [OUTPUT_WIDTH-1:0]        fib_result,
  input  logic                           fib_overflow,
  input  logic                           fib_done
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]    WD_LIMIT  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [ID_W-1:0]    LAST_INIT = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_CLR,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  state_t                   r_state;
  logic [ID_W-1:0]          r_last;
  logic [ID_W-1:0]          r_id;
  logic [WD_W-1:0]          r_wdCnt;
  logic [NUM_REQ-1:0]       r_ack;
  logic [NUM_REQ-1:0]       r_respValid;
  logic [OUTPUT_WIDTH-1:0]  r_respResult;
  logic                     r_respOverflow;
  logic                     r_respError;
  logic                     r_busy;
  logic                     r_fibGo;
  logic [INPUT_WIDTH-1:0]   r_fibN;

  logic                     w_found;
  logic [ID_W-1:0]          w_grantId;
  logic [ID_W-1:0]          w_idx;
  logic [INPUT_WIDTH-1:0]   w_grantN;
  logic [WD_W-1:0]          w_wdNext;
  logic                     w_wdExpired;

  // Round-robin search: start just after the last served requester and take
  // the first active request, wrapping modulo NUM_REQ.
  always_comb begin
    w_found   = 1'b0;
    w_grantId = '0;
    w_idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found   = 1'b1;
        w_grantId = w_idx;
      end
    end
  end

  assign w_grantN = req_n[w_grantId*INPUT_WIDTH +: INPUT_WIDTH];

  // The limit is compared against the incremented count so the abort lands
  // exactly TIMEOUT_CYCLES cycles after entering WAIT_CLR.
  assign w_wdNext    = r_wdCnt + 1'b1;
  assign w_wdExpired = (TIMEOUT_CYCLES != 0) && (w_wdNext == WD_LIMIT);

  // Sequencer FSM. ack, fib_go and resp_valid default low each cycle so they
  // come out as single-cycle pulses; everything else holds until rewritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_last         <= LAST_INIT;
      r_id           <= '0;
      r_wdCnt        <= '0;
      r_ack          <= '0;
      r_respValid    <= '0;
      r_respResult   <= '0;
      r_respOverflow <= 1'b0;
      r_respError    <= 1'b0;
      r_busy         <= 1'b0;
      r_fibGo        <= 1'b0;
      r_fibN         <= '0;
    end else begin
      r_ack       <= '0;
      r_respValid <= '0;
      r_fibGo     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id    <= w_grantId;
            r_fibN  <= w_grantN;
            r_ack   <= ONE_HOT0 << w_grantId;
            r_fibGo <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_wdCnt <= '0;
          r_state <= S_WAIT_CLR;
        end
        // A done still high here belongs to the previous job; wait for it
        // to drop before trusting the next rise.
        S_WAIT_CLR: begin
          r_wdCnt <= w_wdNext;
          if (w_wdExpired) begin
            r_respResult   <= '0;
            r_respOverflow <= 1'b0;
            r_respError    <= 1'b1;
            r_respValid    <= ONE_HOT0 << r_id;
            r_state        <= S_RESPOND;
          end else if (!fib_done) begin
            r_state <= S_WAIT_DONE;
          end
        end
        // Completion is checked before the watchdog so a done arriving on
        // the limit cycle still counts as success.
        S_WAIT_DONE: begin
          r_wdCnt <= w_wdNext;
          if (fib_done) begin
            r_respResult   <= fib_result;
            r_respOverflow <= fib_overflow;
            r_respError    <= 1'b0;
            r_respValid    <= ONE_HOT0 << r_id;
            r_state        <= S_RESPOND;
          end else if (w_wdExpired) begin
            r_respResult   <= '0;
            r_respOverflow <= 1'b0;
            r_respError    <= 1'b1;
            r_respValid    <= ONE_HOT0 << r_id;
            r_state        <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          r_last  <= r_id;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack           = r_ack;
  assign resp_valid    = r_respValid;
  assign resp_result   = r_respResult;
  assign resp_overflow = r_respOverflow;
  assign resp_error    = r_respError;
  assign busy          = r_busy;
  assign fib_go        = r_fibGo;
  assign fib_n         = r_fibN;

endmodule

// File: tb/tb_fib_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fib_arbiter
//
// Drives directed jobs into fib_arbiter through a behavioural fib stub with a
// fixed latency and selectable misbehaviour (stuck done, stale done). Expected
// acks and responses are queued when a job is issued and a negedge monitor
// pops and compares them whenever the DUT pulses ack or resp_valid.
// -----------------------------------------------------------------------------
module tb_fib_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IW      = 6;
  localparam int OW      = 32;
  localparam int TMO     = 16;
  localparam int LAT     = 6;

  typedef struct {
    int          id;
    logic [31:0] result;
    logic        ovf;
    logic        err;
    logic        checkResult;
  } resp_t;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*IW-1:0] reqN;
  logic [NUM_REQ-1:0]    ack;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [OW-1:0]         resp_result;
  logic                  resp_overflow;
  logic                  resp_error;
  logic                  busy;
  logic                  fib_go;
  logic [IW-1:0]         fib_n;
  logic [OW-1:0]         fibResult;
  logic                  fibOverflow;
  logic                  fibDone;

  int    vectorsApplied;
  int    miscompares;
  int    ackQ[$];
  resp_t respQ[$];

  int          stubMode;
  logic [IW-1:0] stubN;
  int          stubCnt;
  logic        stubBusy;

  logic          prevGo;
  logic          prevBusy;
  logic [IW-1:0] prevFibN;
  int            expId;
  resp_t         expResp;

  fib_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .INPUT_WIDTH   (IW),
    .OUTPUT_WIDTH  (OW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_n        (reqN),
    .ack          (ack),
    .resp_valid   (resp_valid),
    .resp_result  (resp_result),
    .resp_overflow(resp_overflow),
    .resp_error   (resp_error),
    .busy         (busy),
    .fib_go       (fib_go),
    .fib_n        (fib_n),
    .fib_result   (fibResult),
    .fib_overflow (fibOverflow),
    .fib_done     (fibDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: bumps the vector count, reports and counts a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic resp_t makeResp(input int id, input logic [31:0] result,
                                     input logic ovf, input logic err,
                                     input logic checkResult);
    resp_t r;
    r.id          = id;
    r.result      = result;
    r.ovf         = ovf;
    r.err         = err;
    r.checkResult = checkResult;
    return r;
  endfunction

  // Behavioural fib used only by the stub; {overflow, result}.
  function automatic logic [32:0] fibModel(input logic [IW-1:0] n);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return {(a[63:32] != 32'd0), a[31:0]};
  endfunction

  // fib stub: mode 0 normal, mode 1 done stuck low, mode 2 keeps a stale
  // done high for 3 cycles after go before the real completion.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fibDone     <= 1'b0;
      fibResult   <= '0;
      fibOverflow <= 1'b0;
      stubN       <= '0;
      stubCnt     <= 0;
      stubBusy    <= 1'b0;
    end else if (fib_go) begin
      stubN    <= fib_n;
      stubCnt  <= 0;
      stubBusy <= (stubMode != 1);
      if (stubMode == 2) begin
        fibDone   <= 1'b1;
        fibResult <= 32'hDEADBEEF;
      end else begin
        fibDone <= 1'b0;
      end
    end else if (stubBusy) begin
      stubCnt <= stubCnt + 1;
      if (stubMode == 2 && stubCnt == 2) fibDone <= 1'b0;
      if (stubCnt == LAT - 1) begin
        {fibOverflow, fibResult} <= fibModel(stubN);
        fibDone  <= 1'b1;
        stubBusy <= 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops plus handshake invariants, sampled on negedge.
  always @(negedge clk) begin
    if (rst) begin
      if (ack != '0) begin
        if (ackQ.size() == 0) begin
          checkOutput("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          expId = ackQ.pop_front();
          checkOutput("ack_order", 64'(ack), 64'd1 << expId);
        end
      end
      if (resp_valid != '0) begin
        if (respQ.size() == 0) begin
          checkOutput("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          expResp = respQ.pop_front();
          checkOutput("resp_id", 64'(resp_valid), 64'd1 << expResp.id);
          checkOutput("resp_error", 64'(resp_error), 64'(expResp.err));
          checkOutput("resp_overflow", 64'(resp_overflow), 64'(expResp.ovf));
          if (expResp.checkResult)
            checkOutput("resp_result", 64'(resp_result), 64'(expResp.result));
        end
      end
      checkOutput("ack_onehot0", 64'($onehot0(ack)), 64'd1);
      checkOutput("resp_onehot0", 64'($onehot0(resp_valid)), 64'd1);
      checkOutput("go_with_ack", 64'(fib_go), 64'(|ack));
      if (prevGo) checkOutput("fib_go_pulse", 64'(fib_go), 64'd0);
      if (busy && prevBusy) checkOutput("fib_n_stable", 64'(fib_n), 64'(prevFibN));
      prevGo   <= fib_go;
      prevBusy <= busy;
      prevFibN <= fib_n;
    end else begin
      prevGo   <= 1'b0;
      prevBusy <= 1'b0;
      prevFibN <= '0;
    end
  end

  task automatic setReq(input int id, input logic [IW-1:0] n, input logic on);
    req[id]           = on;
    reqN[id*IW +: IW] = n;
  endtask

  // Called at a negedge; returns at a negedge with the DUT in IDLE.
  task automatic waitIdle(input string name);
    int cycles;
    cycles = 0;
    while (busy !== 1'b0 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput(name, 64'(cycles < 200), 64'd1);
  endtask

  // Single job: checks ack at t+1 and the ack-to-resp_valid latency.
  task automatic applyStimulus(input int id, input logic [IW-1:0] n,
                               input logic [31:0] expResult, input logic expOvf,
                               input logic expErr, input logic chkResult,
                               input int expLatency);
    int lat;
    waitIdle("idle_before_job");
    ackQ.push_back(id);
    respQ.push_back(makeResp(id, expResult, expOvf, expErr, chkResult));
    setReq(id, n, 1'b1);
    @(negedge clk);
    checkOutput("ack_latency", 64'(ack), 64'd1 << id);
    req[id] = 1'b0;
    lat = 0;
    while (resp_valid == '0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("resp_latency", 64'(lat), 64'(expLatency));
    waitIdle("idle_after_job");
  endtask

  // Requesters 0 and 3 both request; checks who wins from the current pointer.
  task automatic applyPair(input int expWinner, input logic [31:0] expResult);
    waitIdle("idle_before_pair");
    ackQ.push_back(expWinner);
    respQ.push_back(makeResp(expWinner, expResult, 1'b0, 1'b0, 1'b1));
    setReq(0, 6'd6, 1'b1);
    setReq(3, 6'd7, 1'b1);
    @(negedge clk);
    checkOutput("pair_winner", 64'(ack), 64'd1 << expWinner);
    req = '0;
    waitIdle("idle_after_pair");
  endtask

  initial begin : globalTimeout
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  initial begin : stimulus
    int got;
    int cyc;
    vectorsApplied = 0;
    miscompares    = 0;
    stubMode       = 0;
    req            = '0;
    reqN           = '0;
    rst            = 1'b1;

    // Reset values
    #3 rst = 1'b0;
    #1;
    checkOutput("reset_outputs",
                64'({ack, resp_valid, resp_result, resp_overflow, resp_error,
                     busy, fib_go, fib_n}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of WAIT_DONE: job lost, outputs drop at once
    ackQ.push_back(0);
    setReq(0, 6'd10, 1'b1);
    @(negedge clk);
    checkOutput("abort_job_ack", 64'(ack), 64'd1);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busy_before_reset", 64'(busy), 64'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("midjob_reset_outputs",
                64'({ack, resp_valid, resp_result, resp_overflow, resp_error,
                     busy, fib_go, fib_n}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Requester 0 wins first after reset, fib(10)=55
    applyStimulus(0, 6'd10, 32'd55, 1'b0, 1'b0, 1'b1, 8);

    // Overflow: fib(63) does not fit in 32 bits
    applyStimulus(2, 6'd63, 32'd0, 1'b1, 1'b0, 1'b0, 8);

    // Priority wrap: after 3, {0,3} -> 0 (fib(6)=8); after 0, {0,3} -> 3 (fib(7)=13)
    applyStimulus(3, 6'd5, 32'd5, 1'b0, 1'b0, 1'b1, 8);
    applyPair(0, 32'd8);
    applyPair(3, 32'd13);

    // Round robin with all four held: grants 0,1,2,3,0
    waitIdle("idle_before_rr");
    ackQ.push_back(0);
    ackQ.push_back(1);
    ackQ.push_back(2);
    ackQ.push_back(3);
    ackQ.push_back(0);
    respQ.push_back(makeResp(0, 32'd1, 1'b0, 1'b0, 1'b1));
    respQ.push_back(makeResp(1, 32'd1, 1'b0, 1'b0, 1'b1));
    respQ.push_back(makeResp(2, 32'd2, 1'b0, 1'b0, 1'b1));
    respQ.push_back(makeResp(3, 32'd3, 1'b0, 1'b0, 1'b1));
    respQ.push_back(makeResp(0, 32'd1, 1'b0, 1'b0, 1'b1));
    setReq(0, 6'd1, 1'b1);
    setReq(1, 6'd2, 1'b1);
    setReq(2, 6'd3, 1'b1);
    setReq(3, 6'd4, 1'b1);
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) got++;
    end
    req = '0;
    checkOutput("rr_ack_count", 64'(got), 64'd5);
    waitIdle("idle_after_rr");

    // Watchdog: done never rises, abort 16 cycles after entering WAIT_CLR
    stubMode = 1;
    applyStimulus(1, 6'd9, 32'd0, 1'b0, 1'b1, 1'b1, TMO + 1);
    stubMode = 0;

    // Stale done held over go must not complete the job; fib(12)=144
    stubMode = 2;
    applyStimulus(3, 6'd12, 32'd144, 1'b0, 1'b0, 1'b1, 8);
    stubMode = 0;

    // Normal job after the fault modes; error flag cleared again
    applyStimulus(1, 6'd9, 32'd34, 1'b0, 1'b0, 1'b1, 8);

    repeat (4) @(negedge clk);
    checkOutput("ack_queue_drained", 64'(ackQ.size()), 64'd0);
    checkOutput("resp_queue_drained", 64'(respQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
